// File: rtl/mux_pkg.sv
// Shared constants for the registered N-channel multiplexer: operating-mode
// encodings, default datapath dimensions and the select-width helper.
package mux_pkg;

    // Operating mode carried on modo_i.
    localparam logic MODO_FIXO    = 1'b0;
    localparam logic MODO_RODIZIO = 1'b1;

    // Default dimensions shared with the datapath.
    localparam int LARGURA_PADRAO = 32;
    localparam int CANAIS_PADRAO  = 4;

    // Width of a channel index: max(1, clog2(canais)).
    function automatic int sel_w(input int canais);
        return (canais <= 2) ? 1 : $clog2(canais);
    endfunction

endpackage

// File: rtl/arbitro_rodizio.sv
// Round-robin arbiter: holds the rotating priority pointer and picks the first
// valid channel at or above it, wrapping modulo CANAIS.
module arbitro_rodizio
    import mux_pkg::*;
#(
    parameter int CANAIS = CANAIS_PADRAO,
    parameter int SEL_W  = sel_w(CANAIS)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [CANAIS-1:0] validos_i,
    input  logic              avanca_i,   // a round-robin transfer happens this cycle
    output logic [SEL_W-1:0]  indice_o,
    output logic              concede_o
);

    logic [SEL_W-1:0] ponteiro_q;
    logic [SEL_W-1:0] ponteiro_d;
    int               idx;

    // Scan from the pointer upward; walking the offsets downward lets the
    // lowest offset (the highest-priority hit) overwrite the others.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        indice_o  = '0;
        concede_o = 1'b0;
        idx       = 0;
        for (int k = CANAIS - 1; k >= 0; k--) begin
            idx = int'(ponteiro_q) + k;
            if (idx >= CANAIS) begin
                idx = idx - CANAIS;
            end
            if (validos_i[idx]) begin
                indice_o  = SEL_W'(idx);
                concede_o = 1'b1;
            end
        end
    end

    // Next pointer: one past the winner, wrapping explicitly so that
    // non-power-of-two channel counts return to 0.
    always_comb begin
        ponteiro_d = ponteiro_q;
        if (avanca_i && concede_o) begin
            if (int'(indice_o) == CANAIS - 1) begin
                ponteiro_d = '0;
            end else begin
                ponteiro_d = indice_o + SEL_W'(1);
            end
        end
    end

    // Pointer register with synchronous reset.
    always_ff @(posedge clock_i) begin
        // NOTE: sequential state is always written with non-blocking assignments.
        if (reset_i) begin
            ponteiro_q <= '0;
        end else begin
            ponteiro_q <= ponteiro_d;
        end
    end

endmodule

// File: rtl/mux_n_canais_registrado.sv
// Registered N-channel, W-bit multiplexer with valid/ready handshake. Selects a
// channel by explicit index (fixed mode) or round-robin, then registers it.
// Optional feature: define MUX_PARIDADE_EN to add a registered even-parity
// output (paridade_o) alongside resultado_o.
module mux_n_canais_registrado
    import mux_pkg::*;
#(
    parameter  int LARGURA = LARGURA_PADRAO,
    parameter  int CANAIS  = CANAIS_PADRAO,
    localparam int SEL_W   = sel_w(CANAIS)
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic [CANAIS*LARGURA-1:0] entradas_i,
    input  logic [CANAIS-1:0]         validos_i,
    output logic [CANAIS-1:0]         aceitos_o,
    input  logic [SEL_W-1:0]          controle_i,
    input  logic                      modo_i,
    output logic [LARGURA-1:0]        resultado_o,
    output logic [SEL_W-1:0]          canal_saida_o,
    output logic                      valido_saida_o,
    input  logic                      pronto_saida_i
`ifdef MUX_PARIDADE_EN
    ,
    output logic                      paridade_o
`endif
);

    localparam int CANAIS_POT = 1 << SEL_W;

    logic [CANAIS_POT-1:0] validos_ext;   // zero-padded so any controle_i value indexes safely
    logic [SEL_W-1:0]      indice_rr;
    logic                  concede_rr;
    logic [SEL_W-1:0]      indice;
    logic                  concede;
    logic                  carrega;
    logic [LARGURA-1:0]    dado;

    logic [LARGURA-1:0]    resultado_q, resultado_d;
    logic [SEL_W-1:0]      canal_q, canal_d;
    logic                  valido_q, valido_d;
`ifdef MUX_PARIDADE_EN
    logic                  paridade_q, paridade_d;
`endif

    // The output register may load when empty or when its word leaves this cycle.
    assign carrega = !valido_q || pronto_saida_i;

    arbitro_rodizio #(
        .CANAIS (CANAIS),
        .SEL_W  (SEL_W)
    ) u_arbitro (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .validos_i (validos_i),
        .avanca_i  (carrega && (modo_i == MODO_RODIZIO)),
        .indice_o  (indice_rr),
        .concede_o (concede_rr)
    );

    // Grant selection: explicit index in fixed mode (out-of-range reads a padded 0).
    always_comb begin
        validos_ext               = '0;
        validos_ext[CANAIS-1:0]   = validos_i;
        if (modo_i == MODO_RODIZIO) begin
            indice  = indice_rr;
            concede = concede_rr;
        end else begin
            indice  = controle_i;
            concede = validos_ext[controle_i];
        end
    end

    // Data mux and one-hot accept for the granted channel.
    always_comb begin
        dado      = '0;
        aceitos_o = '0;
        for (int i = 0; i < CANAIS; i++) begin
            if (int'(indice) == i) begin
                dado         = entradas_i[i*LARGURA +: LARGURA];
                aceitos_o[i] = carrega && concede;
            end
        end
    end

    // Output-stage next state: load on transfer, drop valid on an empty load, else hold.
    always_comb begin
        resultado_d = resultado_q;
        canal_d     = canal_q;
        valido_d    = valido_q;
`ifdef MUX_PARIDADE_EN
        paridade_d  = paridade_q;
`endif
        if (carrega) begin
            valido_d = concede;
            if (concede) begin
                resultado_d = dado;
                canal_d     = indice;
`ifdef MUX_PARIDADE_EN
                paridade_d  = ^dado;
`endif
            end
        end
    end

    // Output register with synchronous reset; a held word is discarded on reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            resultado_q <= '0;
            canal_q     <= '0;
            valido_q    <= 1'b0;
`ifdef MUX_PARIDADE_EN
            paridade_q  <= 1'b0;
`endif
        end else begin
            resultado_q <= resultado_d;
            canal_q     <= canal_d;
            valido_q    <= valido_d;
`ifdef MUX_PARIDADE_EN
            paridade_q  <= paridade_d;
`endif
        end
    end

    assign resultado_o    = resultado_q;
    assign canal_saida_o  = canal_q;
    assign valido_saida_o = valido_q;
`ifdef MUX_PARIDADE_EN
    assign paridade_o     = paridade_q;
`endif

endmodule

// File: tb/tb_mux_n_canais_registrado.sv
// Directed bench for mux_n_canais_registrado: a 3-channel/3-bit instance for
// fixed mode, out-of-range index and wrap, and a 4-channel/8-bit instance for
// round-robin, stall, no-bubble reload and reset during a stall.
module tb_mux_n_canais_registrado;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 3-channel, 3-bit instance.
    logic [8:0] e3;
    logic [2:0] v3, a3, r3;
    logic [1:0] c3, cs3;
    logic       m3, vo3, p3;
    // 4-channel, 8-bit instance.
    logic [31:0] e4;
    logic [3:0]  v4, a4;
    logic [7:0]  r4;
    logic [1:0]  c4, cs4;
    logic        m4, vo4, p4;
`ifdef MUX_PARIDADE_EN
    logic par3, par4;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mux_n_canais_registrado #(.LARGURA(3), .CANAIS(3)) u_dut3 (
        .clock_i        (clk),
        .reset_i        (rst),
        .entradas_i     (e3),
        .validos_i      (v3),
        .aceitos_o      (a3),
        .controle_i     (c3),
        .modo_i         (m3),
        .resultado_o    (r3),
        .canal_saida_o  (cs3),
        .valido_saida_o (vo3),
        .pronto_saida_i (p3)
`ifdef MUX_PARIDADE_EN
        ,
        .paridade_o     (par3)
`endif
    );

    mux_n_canais_registrado #(.LARGURA(8), .CANAIS(4)) u_dut4 (
        .clock_i        (clk),
        .reset_i        (rst),
        .entradas_i     (e4),
        .validos_i      (v4),
        .aceitos_o      (a4),
        .controle_i     (c4),
        .modo_i         (m4),
        .resultado_o    (r4),
        .canal_saida_o  (cs4),
        .valido_saida_o (vo4),
        .pronto_saida_i (p4)
`ifdef MUX_PARIDADE_EN
        ,
        .paridade_o     (par4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        e3 = '0; v3 = '0; c3 = '0; m3 = 1'b0; p3 = 1'b1;
        e4 = '0; v4 = '0; c4 = '0; m4 = 1'b0; p4 = 1'b1;
        step();
        step();
        check("rst_vo3", vo3, 0);
        check("rst_r3",  r3,  0);
        check("rst_cs3", cs3, 0);
        check("rst_vo4", vo4, 0);
        check("rst_r4",  r4,  0);
`ifdef MUX_PARIDADE_EN
        check("rst_par3", par3, 0);
`endif
        rst = 1'b0;

        // Fixed mode, 3 channels: ch2=000, ch1=010, ch0=111.
        e3 = {3'b000, 3'b010, 3'b111};
        v3 = 3'b111;
        c3 = 2'd1;
        #1 check("fixo_acc_c1", a3, 3'b010);
        step();
        check("fixo_r_c1",  r3, 3'b010);
        check("fixo_cs_c1", cs3, 1);
        check("fixo_vo_c1", vo3, 1);
`ifdef MUX_PARIDADE_EN
        check("fixo_par_010", par3, 1);
`endif
        c3 = 2'd2;
        #1 check("fixo_acc_c2", a3, 3'b100);
        step();
        check("fixo_r_c2", r3, 3'b000);
`ifdef MUX_PARIDADE_EN
        check("fixo_par_000", par3, 0);
`endif
        c3 = 2'd0;
        step();
        check("fixo_r_c0",  r3, 3'b111);
        check("fixo_cs_c0", cs3, 0);
`ifdef MUX_PARIDADE_EN
        check("fixo_par_111", par3, 1);
`endif
        e3 = {3'b000, 3'b011, 3'b111};
        c3 = 2'd1;
        step();
        check("fixo_r_011", r3, 3'b011);
`ifdef MUX_PARIDADE_EN
        check("fixo_par_011", par3, 0);
`endif

        // Out-of-range index: no grant, valid drops, data and channel hold.
        c3 = 2'd3;
        #1 check("fixo_c3_acc", a3, 3'b000);
        step();
        check("fixo_c3_vo", vo3, 0);
        check("fixo_c3_r",  r3, 3'b011);
        check("fixo_c3_cs", cs3, 1);

        // Round-robin on 3 channels: pointer untouched by fixed transfers, wraps 2->0.
        m3 = 1'b1;
        c3 = 2'd0;
        #1 check("rr3_acc0", a3, 3'b001);
        step();
        check("rr3_cs_a", cs3, 0);
        check("rr3_r_a",  r3, 3'b111);
        step();
        check("rr3_cs_b", cs3, 1);
        step();
        check("rr3_cs_c", cs3, 2);
        check("rr3_r_c",  r3, 3'b000);
        step();
        check("rr3_wrap", cs3, 0);
        v3 = '0;

        // Round-robin on 4 channels, all valid.
        e4 = {8'h44, 8'h33, 8'h22, 8'h11};
        v4 = 4'b1111;
        m4 = 1'b1;
        #1 check("rr4_acc_first", a4, 4'b0001);
        step();
        check("rr4_cs0", cs4, 0);
        check("rr4_r0",  r4, 8'h11);
        step();
        check("rr4_cs1", cs4, 1);
        check("rr4_r1",  r4, 8'h22);
        step();
        check("rr4_cs2", cs4, 2);
        step();
        check("rr4_cs3", cs4, 3);
        check("rr4_r3",  r4, 8'h44);
        step();
        check("rr4_cs0b", cs4, 0);

        // Sparse valids: pointer at 1, so grants go 1,3,1,3.
        v4 = 4'b1010;
        step();
        check("rr4_sp_a", cs4, 1);
        step();
        check("rr4_sp_b", cs4, 3);
        step();
        check("rr4_sp_c", cs4, 1);
        step();
        check("rr4_sp_d", cs4, 3);
        check("rr4_sp_r", r4, 8'h44);

        // Stall for three cycles while the inputs change.
        p4 = 1'b0;
        for (int s = 0; s < 3; s++) begin
            e4 = {8'hA0, 8'hB0, 8'hC0, 8'hD0} + 32'(s);
            #1 check("stall_acc", a4, 4'b0000);
            step();
            check("stall_r",  r4, 8'h44);
            check("stall_cs", cs4, 3);
            check("stall_vo", vo4, 1);
        end
        // Release: pointer at 0, first valid is ch1, loads with no bubble.
        e4 = {8'h5A, 8'h6B, 8'h7C, 8'h8D};
        p4 = 1'b1;
        #1 check("release_acc", a4, 4'b0010);
        step();
        check("release_vo", vo4, 1);
        check("release_r",  r4, 8'h7C);
        check("release_cs", cs4, 1);

        // Reset while stalled: held word discarded, pointer back to 0.
        p4 = 1'b0;
        #1 check("prerst_acc", a4, 4'b0000);
        rst = 1'b1;
        step();
        check("midrst_vo", vo4, 0);
        check("midrst_r",  r4, 0);
        check("midrst_cs", cs4, 0);
        rst = 1'b0;
        v4 = 4'b1111;
        p4 = 1'b1;
        #1 check("postrst_acc", a4, 4'b0001);
        step();
        check("postrst_cs", cs4, 0);
        check("postrst_r",  r4, 8'h8D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux_n_canais_registrado.md
# mux_n_canais_registrado

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshake, the successor to the fixed 3-channel combinational selector in the single-cycle datapath. Selects one of CANAIS sources, either by explicit Controle index or by round-robin arbitration among valid sources, and presents the winner through one output register stage. Sits between multiple producers (register file ports, immediate generator, forwarding paths) and one consumer that may stall.

## Interface
- LARGURA, 32: data width in bits per channel (≥1).
- CANAIS, 4: number of input channels (2..16); SEL_W = max(1, clog2(CANAIS)).
- Clock  input  1  single clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Entradas  input  CANAIS*LARGURA  channel i occupies bits [i*LARGURA +: LARGURA].
- Validos  input  CANAIS  per-channel valid.
- Aceitos  output  CANAIS  per-channel accept, one-hot or zero; combinational.
- Controle  input  SEL_W  channel index used in fixed mode.
- Modo  input  1  0 = MODO_FIXO (Controle), 1 = MODO_RODIZIO (round-robin).
- Resultado  output  LARGURA  registered selected data.
- Canal_saida  output  SEL_W  index of the channel that produced Resultado.
- Valido_saida  output  1  Resultado holds a valid word.
- Pronto_saida  input  1  consumer ready.

## Operation
- Load enable: carrega = !Valido_saida || Pronto_saida.
- Grant (combinational): MODO_FIXO → channel Controle if Controle < CANAIS and Validos[Controle]; else none. MODO_RODIZIO → first valid channel scanning from ponteiro upward, wrapping modulo CANAIS; none if Validos == 0.
- Aceitos[g] = carrega && grant valid; all other bits 0. A source transfers exactly when Validos[i] && Aceitos[i].
- On transfer: Resultado ← Entradas[g], Canal_saida ← g, Valido_saida ← 1.
- carrega with no grant: Valido_saida ← 0; Resultado and Canal_saida hold their last value.
- !carrega (output valid, consumer stalled): Resultado, Canal_saida, Valido_saida hold; Aceitos = 0.
- Round-robin pointer ponteiro (SEL_W bits): on a transfer in MODO_RODIZIO, ponteiro ← (g+1) mod CANAIS, wrapping from CANAIS-1 to 0 also when CANAIS is not a power of two. Transfers in MODO_FIXO leave ponteiro unchanged.
- Modo and Controle are sampled every cycle; a change applies to the next grant only and never disturbs a held output word.
- Controle ≥ CANAIS (non-power-of-two CANAIS) → no grant, no transfer; this is not an error.

## Timing
- Latency: 1 cycle from the transfer edge to Resultado/Valido_saida.
- Throughput: 1 word/cycle while Pronto_saida = 1.
- Output handshake: a word leaves when Valido_saida && Pronto_saida. A held word stays stable until accepted.
- Simultaneous output accept and new grant in the same cycle: the new word loads with no bubble.
- Reset values: Resultado = 0, Canal_saida = 0, Valido_saida = 0, ponteiro = 0. Aceitos = 1 on channel 0 in the first post-reset cycle only if the grant selects channel 0.
- Reset mid-stall: the held word is discarded and not delivered.

## Configuration
- MUX_PARIDADE_EN defined: adds output Paridade (1 bit, even parity = XOR of the selected word), registered alongside Resultado. Reset value 0. Holds with Resultado.
- MUX_PARIDADE_EN undefined: port and register are absent. Behaviour is otherwise identical.

## Structure
- Package mux_pkg: MODO_FIXO / MODO_RODIZIO constants, SEL_W width function, and the default LARGURA/CANAIS constants shared with the datapath.
- Sub-module arbitro_rodizio: holds ponteiro and computes the round-robin grant index and grant-valid from Validos. The top level holds the fixed-mode decode, handshake, and output register.

## Test plan
- Reset, then MODO_FIXO, CANAIS=3, LARGURA=3, Entradas {000,010,111}, all valid, Pronto=1, Controle cycling 1,2,0 → Resultado 010, 000, 111 on successive cycles, each one cycle after its Controle value.
- MODO_RODIZIO, CANAIS=4, all valid, Pronto=1 → Canal_saida 0,1,2,3,0. Validos=1010 → 1,3,1,3.
- Stall: Valido_saida=1, Pronto_saida=0 for 3 cycles while Entradas change → Resultado held, Aceitos=0. Pronto=1 → next word loads in the same cycle with no bubble.
- CANAIS=3, MODO_FIXO, Controle=3 → Aceitos=000, Valido_saida falls to 0 next cycle. MODO_RODIZIO with ponteiro at 2 → wraps to 0.
- Reset asserted during a stall → next edge gives Valido_saida=0, Resultado=0, ponteiro=0, and the held word is never accepted.
- With MUX_PARIDADE_EN, LARGURA=3, word 111 → Paridade=1; word 011 → Paridade=0, with the same latency as Resultado.
